lcd_text_scanner: RTL

Raster-to-text sequencer for the LCD debug screen. It tracks the panel's pixel position and drives the `column`/`row` inputs of the character-cell generator. It then fetches the glyph row from the synchronous font ROM and emits one RGB pixel per consumed pixel, at a fixed 3-cycle latency. It sits between the LCD timing generator (pixel consumer) and the debug character generator plus font ROM.

---
 rtl/lcd_text_scanner.sv | 97 +++++++++
 1 files changed

// File: rtl/lcd_text_scanner.sv
// Raster-to-text sequencer: walks the LCD pixel position, drives the character
// generator and the font ROM, and emits one RGB pixel per consumed pixel, 3 cycles later.
module lcd_text_scanner #(
  parameter int          H_PIXELS = 800,
  parameter int          V_PIXELS = 480,
  parameter int          CHAR_W   = 8,
  parameter int          CHAR_H   = 8,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pixel_req,
  output logic [6:0]  column,
  output logic [5:0]  row,
  input  logic [6:0]  character,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel_valid,
  output logic [23:0] pixel_rgb,
  output logic        sync_error
);
  localparam int STAGES = 3;

  logic [9:0]        x, eff_x, nxt_x;
  logic [8:0]        y, eff_y, nxt_y;
  logic              origin_ok, overrun;
  logic [STAGES:1]   vld_pipe;
  logic [6:0]        s1_char;
  logic [2:0]        s1_grow, s1_bit, s2_bit;

  // frame_start makes the current cycle's pixel (0,0) regardless of the counters
  always_comb begin
    eff_x  = frame_start ? '0 : x;
    eff_y  = frame_start ? '0 : y;
    column = 7'(eff_x / CHAR_W);
    row    = 6'(eff_y / CHAR_H);
    nxt_x  = x;
    nxt_y  = y;
    if (pixel_req) begin
      if (eff_x == 10'(H_PIXELS - 1)) begin
        nxt_x = '0;
        nxt_y = (eff_y == 9'(V_PIXELS - 1)) ? '0 : eff_y + 9'd1;
      end else begin
        nxt_x = eff_x + 10'd1;
        nxt_y = eff_y;
      end
    end else if (frame_start) begin
      nxt_x = '0;
      nxt_y = '0;
    end
  end

  // origin_ok: counters sit at (0,0) because of reset/frame_start, not a wrap
  assign overrun = pixel_req && !frame_start && !origin_ok && (x == '0) && (y == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      origin_ok  <= 1'b1;
      sync_error <= 1'b0;
    end else begin
      x <= nxt_x;
      y <= nxt_y;
      if (pixel_req)        origin_ok <= 1'b0;
      else if (frame_start) origin_ok <= 1'b1;
      if (frame_start)      sync_error <= 1'b0;
      else if (overrun)     sync_error <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      s1_char   <= '0;
      s1_grow   <= '0;
      s1_bit    <= '0;
      s2_bit    <= '0;
      pixel_rgb <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pixel_req};
      if (pixel_req) begin
        s1_char <= character;
        s1_grow <= 3'(eff_y % CHAR_H);
        s1_bit  <= 3'(eff_x % CHAR_W);
      end
      s2_bit <= s1_bit;
      if (vld_pipe[2])
        pixel_rgb <= font_data[3'd7 - s2_bit] ? FG_COLOR : BG_COLOR;
    end
  end

  assign font_addr   = {s1_char, s1_grow};
  assign pixel_valid = vld_pipe[STAGES];
endmodule
